// File: rtl/register_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// register_scoreboard_pkg
// Shared definitions for the decode / forwarding logic: default physical
// register address width, stall counter width and the PREG bus macro.
// Ports: none (package).
// -----------------------------------------------------------------------------
`ifndef REGISTER_SCOREBOARD_DEFS
`define REGISTER_SCOREBOARD_DEFS
// Physical register address bus of width w.
`define RSB_PREG_BUS(w) logic [(w)-1:0]
`endif

package register_scoreboard_pkg;

    // Default physical register address width (64 physical registers).
    localparam int unsigned PREG_WIDTH_DEF = 6;

    // Default width of the stall performance counter.
    localparam int unsigned CNT_WIDTH_DEF  = 32;

endpackage

// File: rtl/register_scoreboard_lookup.sv
// -----------------------------------------------------------------------------
// scoreboard_lookup
// Combinational hazard check for one decode source operand: the operand is
// used, its physical register is busy, and no done pulse is retiring that
// register this cycle (a same-cycle done is bypassed, so it does not stall).
// Ports:
//   src_enable, src_addr             - decode source operand and its preg
//   busy                             - current busy vector
//   exec_done_valid/addr             - ALU result forwardable this cycle
//   mem_done_valid/addr              - load result forwardable this cycle
//   hazard_c                         - combinational hazard for this operand
// -----------------------------------------------------------------------------
module scoreboard_lookup
    import register_scoreboard_pkg::*;
#(
    parameter  int unsigned PREG_WIDTH = PREG_WIDTH_DEF,
    localparam int unsigned NUM_PREGS  = 1 << PREG_WIDTH
) (
    input  logic                      src_enable,
    input  `RSB_PREG_BUS(PREG_WIDTH)  src_addr,
    input  logic [NUM_PREGS-1:0]      busy,
    input  logic                      exec_done_valid,
    input  `RSB_PREG_BUS(PREG_WIDTH)  exec_done_addr,
    input  logic                      mem_done_valid,
    input  `RSB_PREG_BUS(PREG_WIDTH)  mem_done_addr,
    output logic                      hazard_c
);

    logic exec_bypass_c;
    logic mem_bypass_c;

    // Hazard = used && busy && not being retired by either done port.
    always_comb begin
        exec_bypass_c = exec_done_valid && (exec_done_addr == src_addr);
        mem_bypass_c  = mem_done_valid  && (mem_done_addr  == src_addr);
        hazard_c      = src_enable && busy[src_addr] && !exec_bypass_c && !mem_bypass_c;
    end

endmodule

// File: rtl/register_scoreboard.sv
// -----------------------------------------------------------------------------
// register_scoreboard
// Per-physical-register busy tracking for the decode stage. A register is
// busy from the issue of its producer until its result reaches the
// forwarding network (exec or mem done pulse). Decode stalls while an enabled
// source is busy and not being bypassed this cycle.
// Ports:
//   clk, rst                          - clock, async active-high reset
//   dec_rs_enable/dec_prs_addr        - decode source rs
//   dec_rt_enable/dec_prt_addr        - decode source rt
//   issue_valid, issue_wb_reg,
//   issue_write_addr                  - instruction offered for issue
//   exec_done_valid/addr              - ALU result forwardable
//   mem_done_valid/addr               - load result forwardable
//   flush                             - discard all pending producers
//   dec_stall                         - combinational: decode must hold
//   issue_accept                      - combinational: issue taken
//   busy_count                        - registered popcount of busy vector
//   stall_cycles                      - saturating count of stalled cycles
// -----------------------------------------------------------------------------
module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter  int unsigned PREG_WIDTH = PREG_WIDTH_DEF,
    parameter  int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dec_rs_enable,
    input  logic                      dec_rt_enable,
    input  `RSB_PREG_BUS(PREG_WIDTH)  dec_prs_addr,
    input  `RSB_PREG_BUS(PREG_WIDTH)  dec_prt_addr,
    input  logic                      issue_valid,
    input  logic                      issue_wb_reg,
    input  `RSB_PREG_BUS(PREG_WIDTH)  issue_write_addr,
    input  logic                      exec_done_valid,
    input  `RSB_PREG_BUS(PREG_WIDTH)  exec_done_addr,
    input  logic                      mem_done_valid,
    input  `RSB_PREG_BUS(PREG_WIDTH)  mem_done_addr,
    input  logic                      flush,
    output logic                      dec_stall,
    output logic                      issue_accept,
    output logic [PREG_WIDTH:0]       busy_count,
    output logic [CNT_WIDTH-1:0]      stall_cycles
);

    localparam int unsigned NUM_PREGS = 1 << PREG_WIDTH;
    localparam int unsigned BCNT_W    = PREG_WIDTH + 1;

    logic [NUM_PREGS-1:0] busy_q;
    logic [NUM_PREGS-1:0] busy_d;
    logic [BCNT_W-1:0]    busy_count_q;
    logic [BCNT_W-1:0]    busy_count_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q;
    logic [CNT_WIDTH-1:0] stall_cycles_d;

    logic rs_hazard_c;
    logic rt_hazard_c;
    logic dec_stall_c;
    logic issue_accept_c;
    logic set_en_c;

    // Source rs hazard check.
    scoreboard_lookup #(
        .PREG_WIDTH (PREG_WIDTH)
    ) u_lookup_rs (
        .src_enable      (dec_rs_enable),
        .src_addr        (dec_prs_addr),
        .busy            (busy_q),
        .exec_done_valid (exec_done_valid),
        .exec_done_addr  (exec_done_addr),
        .mem_done_valid  (mem_done_valid),
        .mem_done_addr   (mem_done_addr),
        .hazard_c        (rs_hazard_c)
    );

    // Source rt hazard check.
    scoreboard_lookup #(
        .PREG_WIDTH (PREG_WIDTH)
    ) u_lookup_rt (
        .src_enable      (dec_rt_enable),
        .src_addr        (dec_prt_addr),
        .busy            (busy_q),
        .exec_done_valid (exec_done_valid),
        .exec_done_addr  (exec_done_addr),
        .mem_done_valid  (mem_done_valid),
        .mem_done_addr   (mem_done_addr),
        .hazard_c        (rt_hazard_c)
    );

    // Stall/accept are same-cycle decisions; a flush cycle never stalls.
    always_comb begin
        dec_stall_c    = (rs_hazard_c || rt_hazard_c) && !flush;
        issue_accept_c = issue_valid && !dec_stall_c;
        set_en_c       = issue_accept_c && issue_wb_reg && (issue_write_addr != '0);
    end

    assign dec_stall    = dec_stall_c;
    assign issue_accept = issue_accept_c;
    assign busy_count   = busy_count_q;
    assign stall_cycles = stall_cycles_q;

    // Next busy vector: flush > set > clear; p0 is hard-wired not busy.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (exec_done_valid) begin
                busy_d[exec_done_addr] = 1'b0;
            end
            if (mem_done_valid) begin
                busy_d[mem_done_addr] = 1'b0;
            end
            if (set_en_c) begin
                busy_d[issue_write_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Count is taken from the next vector so it lands with the vector itself.
    always_comb begin
        busy_count_d = '0;
        for (int unsigned i = 0; i < NUM_PREGS; i++) begin
            busy_count_d = busy_count_d + BCNT_W'(busy_d[i]);
        end
    end

    // Saturating stall counter.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (dec_stall_c && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q         <= '0;
            busy_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            busy_q         <= busy_d;
            busy_count_q   <= busy_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_register_scoreboard
// Directed stimulus for register_scoreboard (PREG_WIDTH=6, CNT_WIDTH=4) with a
// behavioural busy-set model compared on every falling edge, plus literal
// expectations at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_register_scoreboard;

    localparam int unsigned PW  = 6;
    localparam int unsigned CW  = 4;
    localparam int          NPR = 64;
    localparam int          SAT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_rs_enable, dec_rt_enable;
    logic [PW-1:0] dec_prs_addr, dec_prt_addr;
    logic          issue_valid, issue_wb_reg;
    logic [PW-1:0] issue_write_addr;
    logic          exec_done_valid;
    logic [PW-1:0] exec_done_addr;
    logic          mem_done_valid;
    logic [PW-1:0] mem_done_addr;
    logic          flush;
    logic          dec_stall, issue_accept;
    logic [PW:0]   busy_count;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    register_scoreboard #(
        .PREG_WIDTH (PW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dec_rs_enable    (dec_rs_enable),
        .dec_rt_enable    (dec_rt_enable),
        .dec_prs_addr     (dec_prs_addr),
        .dec_prt_addr     (dec_prt_addr),
        .issue_valid      (issue_valid),
        .issue_wb_reg     (issue_wb_reg),
        .issue_write_addr (issue_write_addr),
        .exec_done_valid  (exec_done_valid),
        .exec_done_addr   (exec_done_addr),
        .mem_done_valid   (mem_done_valid),
        .mem_done_addr    (mem_done_addr),
        .flush            (flush),
        .dec_stall        (dec_stall),
        .issue_accept     (issue_accept),
        .busy_count       (busy_count),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_busy [NPR];
    int m_stall;

    function automatic bit src_pending(input bit en, input int a);
        if (!en || a == 0 || !m_busy[a]) return 1'b0;
        if (exec_done_valid && int'(exec_done_addr) == a) return 1'b0;
        if (mem_done_valid && int'(mem_done_addr) == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_dec_stall();
        if (flush) return 1'b0;
        return src_pending(dec_rs_enable, int'(dec_prs_addr)) ||
               src_pending(dec_rt_enable, int'(dec_prt_addr));
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NPR; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPR; i++) m_busy[i] <= 1'b0;
            m_stall <= 0;
        end else begin
            if (m_dec_stall() && m_stall < SAT) m_stall <= m_stall + 1;
            if (flush) begin
                for (int i = 0; i < NPR; i++) m_busy[i] <= 1'b0;
            end else begin
                if (exec_done_valid) m_busy[exec_done_addr] <= 1'b0;
                if (mem_done_valid)  m_busy[mem_done_addr]  <= 1'b0;
                if (issue_valid && !m_dec_stall() && issue_wb_reg && issue_write_addr != 0)
                    m_busy[issue_write_addr] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("dec_stall",    32'(dec_stall),    32'(m_dec_stall()));
            chk("issue_accept", 32'(issue_accept), 32'(issue_valid && !m_dec_stall()));
            chk("busy_count",   32'(busy_count),   32'(m_count()));
            chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        dec_rs_enable = 0; dec_rt_enable = 0; dec_prs_addr = '0; dec_prt_addr = '0;
        issue_valid = 0; issue_wb_reg = 0; issue_write_addr = '0;
        exec_done_valid = 0; exec_done_addr = '0;
        mem_done_valid = 0; mem_done_addr = '0;
        flush = 0;
    endtask

    task automatic issue_write(input int a);
        tick();
        clear_in();
        issue_valid = 1; issue_wb_reg = 1; issue_write_addr = PW'(a);
    endtask

    initial begin
        rst = 1;
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_count", 32'(busy_count), 0);
        chk("rst_stall_cycles", 32'(stall_cycles), 0);
        chk("rst_dec_stall", 32'(dec_stall), 0);
        rst = 0;

        // Load-use on p5: three stalled edges, then bypass on mem_done.
        issue_write(5);
        #1 chk("lu_issue_accept", 32'(issue_accept), 1);
        tick(); clear_in();
        dec_rs_enable = 1; dec_prs_addr = 6'd5; issue_valid = 1;
        #1;
        chk("lu_busy_count", 32'(busy_count), 1);
        chk("lu_stall", 32'(dec_stall), 1);
        chk("lu_no_accept", 32'(issue_accept), 0);
        tick(); tick(); tick();
        mem_done_valid = 1; mem_done_addr = 6'd5;
        #1;
        chk("lu_bypass_stall", 32'(dec_stall), 0);
        chk("lu_bypass_accept", 32'(issue_accept), 1);
        chk("lu_stall_cycles", 32'(stall_cycles), 3);
        tick(); clear_in();
        #1 chk("lu_busy_after", 32'(busy_count), 0);

        // Set/clear collision on p7: new producer wins.
        issue_write(7);
        issue_write(7);
        exec_done_valid = 1; exec_done_addr = 6'd7;
        #1 chk("col_count_before", 32'(busy_count), 1);
        tick(); clear_in();
        dec_rt_enable = 1; dec_prt_addr = 6'd7;
        #1;
        chk("col_busy_count", 32'(busy_count), 1);
        chk("col_stall", 32'(dec_stall), 1);
        tick(); clear_in();
        exec_done_valid = 1; exec_done_addr = 6'd7;
        tick(); clear_in();
        #1 chk("col_cleared", 32'(busy_count), 0);

        // p0 is never busy.
        issue_write(0);
        tick(); clear_in();
        dec_rs_enable = 1; dec_rt_enable = 1; issue_valid = 1;
        #1;
        chk("p0_stall", 32'(dec_stall), 0);
        chk("p0_count", 32'(busy_count), 0);

        // Dual clear in one cycle, and a done to a non-busy register.
        issue_write(1);
        issue_write(2);
        tick(); clear_in();
        exec_done_valid = 1; exec_done_addr = 6'd1;
        mem_done_valid = 1; mem_done_addr = 6'd2;
        #1 chk("dual_before", 32'(busy_count), 2);
        tick(); clear_in();
        exec_done_valid = 1; exec_done_addr = 6'd30;
        #1 chk("dual_after", 32'(busy_count), 0);
        tick(); clear_in();
        #1 chk("stray_done", 32'(busy_count), 0);

        // Flush with pending p3, p9, p12 and a concurrent issue to p4.
        issue_write(3);
        issue_write(9);
        issue_write(12);
        tick(); clear_in();
        #1 chk("fl_count3", 32'(busy_count), 3);
        flush = 1; issue_valid = 1; issue_wb_reg = 1; issue_write_addr = 6'd4;
        dec_rs_enable = 1; dec_prs_addr = 6'd3;
        #1 chk("fl_stall_forced", 32'(dec_stall), 0);
        tick(); clear_in();
        dec_rs_enable = 1; dec_prs_addr = 6'd3; dec_rt_enable = 1; dec_prt_addr = 6'd4;
        #1;
        chk("fl_count0", 32'(busy_count), 0);
        chk("fl_stall", 32'(dec_stall), 0);

        // Reset mid-stall on p10.
        issue_write(10);
        tick(); clear_in();
        dec_rs_enable = 1; dec_prs_addr = 6'd10; issue_valid = 1;
        tick(); tick();
        rst = 1;
        #1;
        chk("mr_stall", 32'(dec_stall), 0);
        chk("mr_count", 32'(busy_count), 0);
        chk("mr_stall_cycles", 32'(stall_cycles), 0);
        rst = 0;
        tick();
        #1 chk("mr_after", 32'(dec_stall), 0);

        // Saturation of the 4-bit stall counter.
        issue_write(20);
        tick(); clear_in();
        dec_rs_enable = 1; dec_prs_addr = 6'd20; issue_valid = 1;
        repeat (20) tick();
        #1;
        chk("sat_value", 32'(stall_cycles), 15);
        chk("sat_still_stall", 32'(dec_stall), 1);
        mem_done_valid = 1; mem_done_addr = 6'd20;
        tick(); clear_in();
        #1;
        chk("sat_hold", 32'(stall_cycles), 15);
        chk("sat_count", 32'(busy_count), 0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_scoreboard.md
REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 SHALL have parameter PREG_WIDTH, default 6: physical register address width, giving 64 physical registers.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the stall performance counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports dec_rs_enable / dec_rt_enable, input, 1 each: decode source operand is used.
REQ-006 SHALL have ports dec_prs_addr / dec_prt_addr, input, PREG_WIDTH each: decode source physical registers.
REQ-007 SHALL have port issue_valid, input, 1: decode presents an instruction for issue this cycle.
REQ-008 SHALL have ports issue_wb_reg (input, 1) and issue_write_addr (input, PREG_WIDTH): issuing instruction writes issue_write_addr.
REQ-009 SHALL have port exec_done_valid / exec_done_addr, input, 1 / PREG_WIDTH: ALU result becomes forwardable this cycle.
REQ-010 SHALL have port mem_done_valid / mem_done_addr, input, 1 / PREG_WIDTH: load result becomes forwardable this cycle.
REQ-011 SHALL have port flush, input, 1: pipeline flush; discard all pending producers.
REQ-012 SHALL have port dec_stall, output, 1: decode must hold; the issue is not accepted.
REQ-013 SHALL have port issue_accept, output, 1: issue_valid && !dec_stall.
REQ-014 SHALL have port busy_count, output, PREG_WIDTH+1: number of registers currently pending.
REQ-015 SHALL have port stall_cycles, output, CNT_WIDTH: count of cycles with dec_stall asserted.

Function
REQ-016 SHALL keep a busy bit per physical register; busy means the result is not yet available to the forwarding network.
REQ-017 SHALL set busy[issue_write_addr] at the clock edge when issue_accept && issue_wb_reg && issue_write_addr != 0.
REQ-018 SHALL clear busy[exec_done_addr] when exec_done_valid, and clear busy[mem_done_addr] when mem_done_valid, at the clock edge; both may clear in the same cycle.
REQ-019 SHALL let a same-cycle set take priority over a clear to the same address (new producer wins).
REQ-020 SHALL clear all busy bits on flush; flush takes priority over set and clear in that cycle.
REQ-021 SHALL never mark physical register 0 busy; a source read of p0 never stalls.
REQ-022 SHALL compute dec_stall combinationally: an enabled source (rs or rt) whose busy bit is set and which is not being cleared by exec_done or mem_done in the same cycle (same-cycle bypass, 0-cycle latency).
REQ-023 SHALL force dec_stall to 0 while flush is asserted.
REQ-024 SHALL assert dec_stall independently of issue_valid; issue_accept is gated by issue_valid.
REQ-025 SHALL update busy_count registered, in the same cycle as the busy vector, so it always equals the popcount of the busy vector.
REQ-026 SHALL increment stall_cycles by 1 on each edge with dec_stall = 1, saturating at all-ones with no wrap.
REQ-027 SHALL ignore a done pulse addressed to a non-busy register (no state change, no error).

Reset
REQ-028 SHALL, on rst, asynchronously clear all busy bits, busy_count = 0 and stall_cycles = 0; dec_stall is therefore 0 during reset.
REQ-029 SHALL, when reset is asserted while producers are pending, discard them; no clear pulse is required afterwards.

Structure
REQ-030 SHALL place the PREG width constant and the PREG bus macro in the shared defines file used by the decode and forwarding logic.
REQ-031 SHALL instantiate one sub-module, scoreboard_lookup, for the combinational busy-and-not-cleared check, used twice (rs and rt).

Verification
REQ-032 SHALL cover load-use: issue write p5 with a load; next cycle decode reads p5 -> dec_stall = 1 until the mem_done_valid/addr = 5 cycle, where dec_stall = 0 (bypass) and stall_cycles increments by the stalled cycle count.
REQ-033 SHALL cover set/clear collision: issue write p7 while exec_done_addr = 7 -> busy[7] = 1 afterwards, busy_count unchanged.
REQ-034 SHALL cover p0: issue write p0, then read p0 -> no stall, busy_count = 0.
REQ-035 SHALL cover flush: mark p3, p9 and p12 busy (busy_count = 3), assert flush together with an issue to p4 -> busy_count = 0 and dec_stall = 0 next cycle.
REQ-036 SHALL cover reset mid-operation: p10 busy with a stall in progress, pulse rst between edges -> immediately dec_stall = 0, busy_count = 0, stall_cycles = 0.
REQ-037 SHALL cover saturation: with CNT_WIDTH = 4, hold a stall for 20 cycles -> stall_cycles = 15.
